host_cmd_bridge: RTL and testbench

- Upstream stage of the coprocessor controller.
- Accepts a valid/ready stream of 32-bit host words and buffers them. Re-times each command into the controller's fixed, handshake-free word schedule on cmd_word.
- Captures read-back words from the controller's 32-bit out bus into a response FIFO toward the host.
- Guarantees that no write payload is split and no read response is lost.

---
 rtl/host_cmd_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_host_cmd_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_bridge.sv
// host_cmd_bridge: buffers host command words, replays each command onto the
// controller's fixed word schedule and captures read-back words for the host.
module host_cmd_bridge #(
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned RSP_DEPTH = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [31:0] cmd_word,
  input  logic [31:0] ctrl_out,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned IN_CW  = IN_AW + 1;
  localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
  localparam int unsigned RSP_CW = RSP_AW + 1;

  localparam logic [31:0] IDLE_WORD = 32'hC000_0000;
  localparam logic [1:0]  OP_READ   = 2'b00;
  localparam logic [1:0]  OP_WRITE  = 2'b01;
  localparam logic [1:0]  OP_KEY    = 2'b10;
  localparam logic [1:0]  OP_ILL    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAYLOAD, S_COMMIT, S_WAIT, S_GAP
  } state_t;

  // Schedule length in words for a decoded header.
  function automatic logic [3:0] cmd_len(input logic [1:0] op, input logic [4:0] sel);
    logic [3:0] n;
    n = 4'd1;
    if (op == OP_KEY) begin
      case (sel[3:0])
        4'd0, 4'd1: n = 4'd4;
        4'd2:       n = 4'd10;
        default:    n = 4'd1;
      endcase
    end else begin
      case (sel)
        5'd0, 5'd1, 5'd2, 5'd8, 5'd9: n = 4'd4;
        5'd5, 5'd6:                   n = 4'd8;
        5'd12, 5'd13, 5'd14:          n = 4'd5;
        5'd4:                         n = 4'd14;
        5'd7:                         n = 4'd3;
        5'd16:                        n = 4'd2;
        default:                      n = 4'd1;
      endcase
    end
    return n;
  endfunction

  // ---------------- input FIFO ----------------
  logic [31:0]       in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr, in_rd;
  logic [IN_CW-1:0]  in_count, in_count_next;
  logic              in_push, in_pop;
  logic [31:0]       in_head;

  assign in_push       = s_valid && s_ready;
  assign in_head       = in_mem[in_rd];
  assign in_count_next = in_count + IN_CW'(in_push) - IN_CW'(in_pop);

  // Input FIFO pointers, occupancy and ready flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_wr    <= '0;
      in_rd    <= '0;
      in_count <= '0;
      s_ready  <= 1'b0;
    end else begin
      if (in_push) in_wr <= in_wr + IN_AW'(1);
      if (in_pop)  in_rd <= in_rd + IN_AW'(1);
      in_count <= in_count_next;
      s_ready  <= (in_count_next != IN_CW'(IN_DEPTH));
    end
  end

  // Input FIFO storage.
  always_ff @(posedge clock) begin
    if (in_push) in_mem[in_wr] <= s_data;
  end

  // ---------------- response FIFO ----------------
  logic [32:0]       rsp_mem [RSP_DEPTH];
  logic [RSP_AW-1:0] rsp_wr, rsp_rd, rsp_rd_inc;
  logic [RSP_CW-1:0] rsp_count, rsp_count_next, rsp_free;
  logic              rsp_push, rsp_pop;
  logic              cap_q, cap_last_q;

  assign rsp_push       = cap_q;
  assign rsp_pop        = m_valid && m_ready;
  assign rsp_rd_inc     = rsp_rd + RSP_AW'(1);
  assign rsp_count_next = rsp_count + RSP_CW'(rsp_push) - RSP_CW'(rsp_pop);
  // A capture already scheduled for this cycle still needs its slot.
  assign rsp_free       = RSP_CW'(RSP_DEPTH) - rsp_count - RSP_CW'(cap_q);

  // Response FIFO pointers and the registered first-word-fall-through head.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_wr    <= '0;
      rsp_rd    <= '0;
      rsp_count <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      if (rsp_push) rsp_wr <= rsp_wr + RSP_AW'(1);
      if (rsp_pop)  rsp_rd <= rsp_rd_inc;
      rsp_count <= rsp_count_next;
      m_valid   <= (rsp_count_next != '0);
      if (rsp_pop && (rsp_count > RSP_CW'(1))) begin
        {m_last, m_data} <= rsp_mem[rsp_rd_inc];
      end else if (rsp_push && ((rsp_count == '0) || (rsp_pop && (rsp_count == RSP_CW'(1))))) begin
        {m_last, m_data} <= {cap_last_q, ctrl_out};
      end
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clock) begin
    if (rsp_push) rsp_mem[rsp_wr] <= {cap_last_q, ctrl_out};
  end

  // ---------------- header decode / issue rule ----------------
  logic [1:0] hd_op;
  logic [4:0] hd_sel;
  logic [3:0] hd_len;
  logic       hd_present, hd_drop, hd_go;

  assign hd_op      = in_head[31:30];
  assign hd_sel     = in_head[4:0];
  assign hd_len     = cmd_len(hd_op, hd_sel);
  assign hd_present = (in_count != '0);

  // Decide whether the FIFO head is dropped, issued, or left waiting.
  always_comb begin
    hd_drop = 1'b0;
    hd_go   = 1'b0;
    if (hd_present) begin
      if ((hd_op == OP_ILL) ||
          ((hd_op == OP_KEY) && (hd_sel[3:0] >= 4'd3) && (hd_sel[3:0] <= 4'd5))) begin
        hd_drop = 1'b1;
      end else if (hd_op == OP_WRITE) begin
        hd_go = (in_count >= (IN_CW'(hd_len) + IN_CW'(1)));
      end else if (hd_op == OP_READ) begin
        hd_go = (rsp_free >= RSP_CW'(hd_len));
      end else begin
        hd_go = 1'b1;
      end
    end
  end

  // ---------------- schedule FSM ----------------
  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  cur_op, op_next;
  logic [31:0] cmd_next;
  logic        err_next;

  // Next-state, FIFO pop and next controller word.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = cur_op;
    cmd_next   = IDLE_WORD;
    in_pop     = 1'b0;
    err_next   = 1'b0;
    case (state)
      // GAP also evaluates the head so back-to-back commands keep minimum spacing.
      S_IDLE, S_GAP: begin
        state_next = S_IDLE;
        if (hd_drop) begin
          in_pop   = 1'b1;
          err_next = 1'b1;
        end else if (hd_go) begin
          in_pop     = 1'b1;
          state_next = S_HDR;
          cmd_next   = in_head;
          op_next    = hd_op;
          cnt_next   = hd_len - 4'd1;
        end
      end
      S_HDR: begin
        if (cur_op == OP_WRITE) begin
          in_pop     = 1'b1;
          cmd_next   = in_head;
          state_next = S_PAYLOAD;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_PAYLOAD: begin
        if (cnt != 4'd0) begin
          in_pop   = 1'b1;
          cmd_next = in_head;
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = S_COMMIT;
        end
      end
      S_COMMIT: state_next = S_GAP;
      S_WAIT: begin
        if (cnt != 4'd0) cnt_next = cnt - 4'd1;
        else             state_next = S_GAP;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register, registered outputs and read-capture strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      cur_op     <= OP_ILL;
      cmd_word   <= IDLE_WORD;
      busy       <= 1'b0;
      err        <= 1'b0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cur_op     <= op_next;
      cmd_word   <= cmd_next;
      busy       <= (state_next != S_IDLE);
      err        <= err_next;
      cap_q      <= (state == S_WAIT) && (cur_op == OP_READ);
      cap_last_q <= (state == S_WAIT) && (cur_op == OP_READ) && (cnt == 4'd0);
    end
  end

endmodule

// File: tb/tb_host_cmd_bridge.sv
// Bench for host_cmd_bridge: scoreboarded command schedule and read responses.
`timescale 1ns/1ps
module tb_host_cmd_bridge;

  localparam logic [31:0] IDLE_W = 32'hC000_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        s_valid, s_ready, m_valid, m_ready, m_last, busy, err;
  logic [31:0] s_data, m_data, cmd_word;
  logic [31:0] ctrl_out = 32'h1000_0000;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;
  int err_cnt;
  int busy_cnt;
  int seen_cyc[$];

  typedef struct { logic [31:0] data; int rd_n; } cmd_exp_t;
  typedef struct { logic [31:0] data; logic last; } rsp_exp_t;
  cmd_exp_t exp_cmd[$];
  rsp_exp_t exp_rsp[$];

  host_cmd_bridge #(.IN_DEPTH(16), .RSP_DEPTH(16)) dut (
    .clock(clock), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cmd_word(cmd_word), .ctrl_out(ctrl_out), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Cycle counter and a free-running controller out bus.
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    ctrl_out <= ctrl_out + 32'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle; at the negedge score cmd_word and accepted responses.
  task automatic tick();
    cmd_exp_t ce;
    rsp_exp_t re;
    @(negedge clock);
    if (resetn === 1'b1) begin
      if (err === 1'b1)  err_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (cmd_word !== IDLE_W) begin
        seen_cyc.push_back(cyc);
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got %h, expected idle word", cmd_word);
        end else begin
          ce = exp_cmd.pop_front();
          if (cmd_word !== ce.data) begin
            errors++;
            $display("FAIL cmd_word: got %h, expected %h", cmd_word, ce.data);
          end
          for (int k = 2; k <= ce.rd_n + 1; k++) begin
            re.data = ctrl_out + 32'(k);
            re.last = (k == ce.rd_n + 1);
            exp_rsp.push_back(re);
          end
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got %h last %b, expected nothing", m_data, m_last);
        end else begin
          re = exp_rsp.pop_front();
          if ({m_last, m_data} !== {re.last, re.data}) begin
            errors++;
            $display("FAIL rsp_word: got %h last %b, expected %h last %b",
                     m_data, m_last, re.data, re.last);
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: s_ready %b, expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_cmd_drain(output bit ok);
    int n;
    n = 0;
    while (exp_cmd.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    ok = (exp_cmd.size() == 0);
  endtask

  task automatic wait_rsp_drain(output bit ok);
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    ok = (exp_rsp.size() == 0);
  endtask

  task automatic test_reset();
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checks++; if (cmd_word !== IDLE_W) begin errors++; $display("FAIL reset_cmd: got %h, expected %h", cmd_word, IDLE_W); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b, expected 0", s_ready); end
    checks++; if ({m_valid, m_last, busy, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b, expected 0000", {m_valid, m_last, busy, err}); end
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b, expected 1", s_ready); end
    checks++; if (cmd_word !== IDLE_W) begin errors++; $display("FAIL post_reset_cmd: got %h, expected %h", cmd_word, IDLE_W); end
  endtask

  task automatic test_write_sel7();
    logic [31:0] w[4];
    bit ok;
    w[0] = 32'h4000_0007; w[1] = 32'h0000_AAA1; w[2] = 32'h0000_AAA2; w[3] = 32'h0000_AAA3;
    seen_cyc.delete();
    for (int i = 0; i < 4; i++) exp_cmd.push_back('{w[i], 0});
    for (int i = 0; i < 4; i++) push_word(w[i]);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL wr7_s_ready: got %b, expected 1", s_ready); end
    wait_cmd_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr7_drain: got %0d pending, expected 0", exp_cmd.size()); end
    for (int i = 1; i < seen_cyc.size(); i++) begin
      checks++;
      if (seen_cyc[i] != seen_cyc[0] + i) begin errors++; $display("FAIL wr7_contiguous: word %0d at cycle %0d, expected %0d", i, seen_cyc[i], seen_cyc[0] + i); end
    end
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr7_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_read_sel4();
    bit ok;
    m_ready = 1'b0;
    exp_cmd.push_back('{32'h0000_0004, 14});
    push_word(32'h0000_0004);
    wait_cmd_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd4_issue: got %0d pending, expected 0", exp_cmd.size()); end
    repeat (25) tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rd4_m_valid: got %b, expected 1", m_valid); end
    m_ready = 1'b1;
    wait_rsp_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd4_drain: got %0d words missing, expected 0", exp_rsp.size()); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rd4_extra: m_valid %b, expected 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_write_staggered();
    bit ok;
    int last_push;
    seen_cyc.delete();
    exp_cmd.push_back('{32'h4000_0005, 0});
    for (int i = 1; i <= 8; i++) exp_cmd.push_back('{32'hBBB0_0000 + 32'(i), 0});
    push_word(32'h4000_0005);
    for (int i = 1; i <= 5; i++) push_word(32'hBBB0_0000 + 32'(i));
    repeat (20) tick();
    checks++; if (seen_cyc.size() != 0) begin errors++; $display("FAIL stag_early_issue: got %0d words, expected 0", seen_cyc.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stag_busy: got %b, expected 0", busy); end
    for (int i = 6; i <= 8; i++) push_word(32'hBBB0_0000 + 32'(i));
    last_push = cyc;
    wait_cmd_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stag_drain: got %0d pending, expected 0", exp_cmd.size()); end
    checks++; if (seen_cyc.size() != 9) begin errors++; $display("FAIL stag_count: got %0d words, expected 9", seen_cyc.size()); end
    else begin
      checks++; if (seen_cyc[0] <= last_push) begin errors++; $display("FAIL stag_hdr_time: header at %0d, expected after %0d", seen_cyc[0], last_push); end
      checks++; if (seen_cyc[8] != seen_cyc[0] + 8) begin errors++; $display("FAIL stag_contiguous: last at %0d, expected %0d", seen_cyc[8], seen_cyc[0] + 8); end
    end
    repeat (4) tick();
  endtask

  task automatic test_key();
    seen_cyc.delete();
    err_cnt = 0;
    busy_cnt = 0;
    exp_cmd.push_back('{32'h8000_0002, 0});
    push_word(32'h8000_0002);
    push_word(32'h8000_0004);
    repeat (40) tick();
    checks++; if (seen_cyc.size() != 1) begin errors++; $display("FAIL key_words: got %0d, expected 1", seen_cyc.size()); end
    checks++; if (busy_cnt != 12) begin errors++; $display("FAIL key_busy_cycles: got %0d, expected 12", busy_cnt); end
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL key_err_pulses: got %0d, expected 1", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL key_busy_after: got %b, expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    m_ready = 1'b0;
    exp_cmd.push_back('{32'h0000_0005, 8});
    exp_cmd.push_back('{32'h0000_0010, 2});
    push_word(32'h0000_0005);
    push_word(32'h0000_0010);
    wait_cmd_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_preload: got %0d pending, expected 0", exp_cmd.size()); end
    repeat (10) tick();
    exp_cmd.push_back('{32'h0000_0005, 8});
    push_word(32'h0000_0005);
    repeat (30) tick();
    checks++; if (exp_cmd.size() != 1) begin errors++; $display("FAIL bp_held: got %0d pending, expected 1", exp_cmd.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b, expected 0", busy); end
    m_ready = 1'b1;
    tick();
    tick();
    m_ready = 1'b0;
    wait_cmd_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_issue: got %0d pending, expected 0", exp_cmd.size()); end
    repeat (12) tick();
    m_ready = 1'b1;
    wait_rsp_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d missing, expected 0", exp_rsp.size()); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_extra: m_valid %b, expected 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int n;
    m_ready = 1'b0;
    exp_cmd.push_back('{32'h0000_0010, 2});
    push_word(32'h0000_0010);
    wait_cmd_drain(ok);
    repeat (6) tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmw_preload: m_valid %b, expected 1", m_valid); end
    seen_cyc.delete();
    exp_cmd.push_back('{32'h4000_0000, 0});
    exp_cmd.push_back('{32'hD000_0001, 0});
    push_word(32'h4000_0000);
    for (int i = 1; i <= 4; i++) push_word(32'hD000_0000 + 32'(i));
    n = 0;
    while (seen_cyc.size() == 0 && n < 50) begin tick(); n++; end
    checks++; if (seen_cyc.size() == 0) begin errors++; $display("FAIL rmw_hdr: got no header, expected 4000_0000"); end
    tick();
    resetn = 1'b0;
    #1;
    checks++; if (cmd_word !== IDLE_W) begin errors++; $display("FAIL rmw_cmd_async: got %h, expected %h", cmd_word, IDLE_W); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmw_m_valid: got %b, expected 0", m_valid); end
    checks++; if ({s_ready, busy} !== 2'b00) begin errors++; $display("FAIL rmw_flags: got %b, expected 00", {s_ready, busy}); end
    exp_cmd.delete();
    exp_rsp.delete();
    repeat (2) tick();
    resetn = 1'b1;
    seen_cyc.delete();
    repeat (10) tick();
    checks++; if (seen_cyc.size() != 0) begin errors++; $display("FAIL rmw_stale: got %0d words, expected 0", seen_cyc.size()); end
    checks++; if ({s_ready, m_valid} !== 2'b10) begin errors++; $display("FAIL rmw_fifos: got %b, expected 10", {s_ready, m_valid}); end
    m_ready = 1'b1;
    exp_cmd.push_back('{32'h0000_0010, 2});
    push_word(32'h0000_0010);
    wait_cmd_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmw_read_issue: got %0d pending, expected 0", exp_cmd.size()); end
    wait_rsp_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmw_read_rsp: got %0d missing, expected 0", exp_rsp.size()); end
    repeat (3) tick();
    checks++; if ({m_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmw_final: got %b, expected 00", {m_valid, busy}); end
  endtask

  initial begin
    err_cnt  = 0;
    busy_cnt = 0;
    test_reset();
    test_write_sel7();
    test_read_sel4();
    test_write_staggered();
    test_key();
    test_backpressure();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
